pc_unit: RTL and testbench

//  Parametrised program-counter register for the MIPS core; drives the instruction-fetch Address.

---
 rtl/pc_pkg.sv | 41 ++++
 rtl/pc_unit_md_hold_ctr.sv | 34 +++
 rtl/pc_unit.sv | 101 ++++++++++
 tb/tb_pc_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared decode constants, state type and long-op classifier for pc_unit
package pc_pkg;

   localparam logic [5:0] OP_SPECIAL  = 6'b000000;
   localparam logic [5:0] FUNCT_MULT  = 6'b011000;
   localparam logic [5:0] FUNCT_MULTU = 6'b011001;
   localparam logic [5:0] FUNCT_DIV   = 6'b011010;
   localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

   typedef enum logic {RUN = 1'b0, HOLD = 1'b1} pc_state_t;

   typedef enum logic {CLS_MULT = 1'b0, CLS_DIV = 1'b1} op_class_t;

   typedef struct packed {
      op_class_t cls;
      logic      valid;
   } long_op_t;

   // Classifies an instruction by its opcode and funct fields
   function automatic long_op_t is_long_op(input logic [5:0] opcode,
                                           input logic [5:0] funct);
      long_op_t r;
      r.cls   = CLS_MULT;
      r.valid = 1'b0;
      if (opcode == OP_SPECIAL) begin
         case (funct)
            FUNCT_DIV, FUNCT_DIVU: begin
               r.cls   = CLS_DIV;
               r.valid = 1'b1;
            end
            FUNCT_MULT, FUNCT_MULTU: begin
               r.cls   = CLS_MULT;
               r.valid = 1'b1;
            end
            default: ;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/pc_unit_md_hold_ctr.sv
// rtl/pc_unit_md_hold_ctr.sv - hold-edge counter for multi-cycle MULT/DIV fetch holds
module md_hold_ctr #(
   parameter int CNT_W = 8
) (
   input  logic             PC_CLK,
   input  logic             Reset,
   input  logic             load,
   input  logic             inc,
   input  logic             clear,
   input  logic             freeze,
   input  logic [CNT_W-1:0] lat,
   output logic             done
);

   logic [CNT_W-1:0] count;

   // Clear beats freeze so an exception can abort a stalled hold; load starts at 1
   always_ff @(posedge PC_CLK or posedge Reset) begin
      if (Reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (freeze) begin
         count <= count;
      end else if (load) begin
         count <= CNT_W'(1);
      end else if (inc) begin
         count <= count + CNT_W'(1);
      end
   end

   assign done = (count == lat);

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with exception redirect, MULT/DIV fetch hold and stall; PC_EPC_EN adds epc
module pc_unit
   import pc_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VEC = 32'h00400000,
   parameter logic [WIDTH-1:0] EXC_BASE  = 32'h00400000,
   parameter int               DIV_LAT   = 34,
   parameter int               MULT_LAT  = 0,
   parameter int               CNT_W     = 8
) (
   input  logic             PC_CLK,
   input  logic             Reset,
   input  logic [WIDTH-1:0] instruction,
   input  logic [WIDTH-1:0] npc,
   input  logic             exc_req,
   input  logic [WIDTH-1:0] exc_addr,
   input  logic             ext_stall,
   output logic [WIDTH-1:0] Address,
   output logic             md_busy
`ifdef PC_EPC_EN
   ,
   output logic [WIDTH-1:0] epc
`endif
);

   localparam logic [CNT_W-1:0] DIV_LAT_C  = CNT_W'(DIV_LAT);
   localparam logic [CNT_W-1:0] MULT_LAT_C = CNT_W'(MULT_LAT);

   // A counter that cannot reach LAT would hold fetch forever
   if ((2 ** CNT_W) <= DIV_LAT || (2 ** CNT_W) <= MULT_LAT) begin : g_cnt_w_check
      $error("pc_unit: CNT_W too small for DIV_LAT/MULT_LAT");
   end

   pc_state_t        state;
   op_class_t        hold_cls;
   long_op_t         lop;
   logic [CNT_W-1:0] dec_lat;
   logic [CNT_W-1:0] hold_lat;
   logic             start_hold;
   logic             ctr_done;
   logic             unused_instr_bits;

   assign lop               = is_long_op(instruction[31:26], instruction[5:0]);
   assign dec_lat           = (lop.cls == CLS_DIV) ? DIV_LAT_C : MULT_LAT_C;
   assign start_hold        = lop.valid && (dec_lat != '0);
   assign hold_lat          = (hold_cls == CLS_DIV) ? DIV_LAT_C : MULT_LAT_C;
   assign unused_instr_bits = ^instruction[25:6];

   md_hold_ctr #(.CNT_W(CNT_W)) u_ctr (
      .PC_CLK (PC_CLK),
      .Reset  (Reset),
      .load   (state == RUN && start_hold),
      .inc    (state == HOLD && !ctr_done),
      .clear  (exc_req || (state == HOLD && ctr_done && !ext_stall)),
      .freeze (ext_stall),
      .lat    (hold_lat),
      .done   (ctr_done)
   );

   // Address/state update with priority exc_req > ext_stall > long-op hold > advance
   always_ff @(posedge PC_CLK or posedge Reset) begin
      if (Reset) begin
         Address  <= RESET_VEC;
         state    <= RUN;
         md_busy  <= 1'b0;
         hold_cls <= CLS_MULT;
`ifdef PC_EPC_EN
         epc      <= RESET_VEC;
`endif
      end else if (exc_req) begin
         Address  <= EXC_BASE + exc_addr;
         state    <= RUN;
         md_busy  <= 1'b0;
`ifdef PC_EPC_EN
         epc      <= Address;
`endif
      end else if (!ext_stall) begin
         case (state)
            RUN: begin
               if (start_hold) begin
                  state    <= HOLD;
                  md_busy  <= 1'b1;
                  hold_cls <= lop.cls;
               end else begin
                  Address <= npc;
               end
            end
            HOLD: begin
               if (ctr_done) begin
                  Address <= npc;
                  state   <= RUN;
                  md_busy <= 1'b0;
               end
            end
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit
`timescale 1ns/1ps
module tb_pc_unit;

   logic        PC_CLK = 1'b0;
   int          n_checks = 0;
   int          n_errors = 0;

   logic        Reset;
   logic [31:0] instruction, npc, exc_addr, Address;
   logic        exc_req, ext_stall, md_busy;

   logic        Reset_b;
   logic [31:0] instruction_b, npc_b, exc_addr_b, Address_b;
   logic        exc_req_b, ext_stall_b, md_busy_b;
`ifdef PC_EPC_EN
   logic [31:0] epc, epc_b;
`endif

   localparam logic [31:0] NOP   = 32'h00000000;
   localparam logic [31:0] DIV   = 32'h0000001A;
   localparam logic [31:0] MULT  = 32'h00000018;
   localparam logic [31:0] MULTU = 32'h00000019;

   always #5 PC_CLK = ~PC_CLK;

   pc_unit dut (
      .PC_CLK      (PC_CLK),
      .Reset       (Reset),
      .instruction (instruction),
      .npc         (npc),
      .exc_req     (exc_req),
      .exc_addr    (exc_addr),
      .ext_stall   (ext_stall),
      .Address     (Address),
      .md_busy     (md_busy)
`ifdef PC_EPC_EN
      ,
      .epc         (epc)
`endif
   );

   pc_unit #(.MULT_LAT(4), .EXC_BASE(32'hFFFFFF00)) dut_b (
      .PC_CLK      (PC_CLK),
      .Reset       (Reset_b),
      .instruction (instruction_b),
      .npc         (npc_b),
      .exc_req     (exc_req_b),
      .exc_addr    (exc_addr_b),
      .ext_stall   (ext_stall_b),
      .Address     (Address_b),
      .md_busy     (md_busy_b)
`ifdef PC_EPC_EN
      ,
      .epc         (epc_b)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge PC_CLK);
      #1;
   endtask

   initial begin
      Reset = 1'b1; instruction = NOP; npc = 32'h00400004;
      exc_req = 1'b0; exc_addr = '0; ext_stall = 1'b0;
      Reset_b = 1'b1; instruction_b = NOP; npc_b = 32'h00001000;
      exc_req_b = 1'b0; exc_addr_b = '0; ext_stall_b = 1'b0;
      #2;
      check("reset_addr", Address, 32'h00400000);
      check("reset_busy", {31'b0, md_busy}, 32'd0);
`ifdef PC_EPC_EN
      check("reset_epc", epc, 32'h00400000);
`endif

      // 1: release, run, async reset mid-run, release again
      Reset = 1'b0;
      tick();
      check("first_adv", Address, 32'h00400004);
      npc = 32'h00400010;
      tick();
      check("run_adv", Address, 32'h00400010);
      Reset = 1'b1;
      #1;
      check("async_reset", Address, 32'h00400000);
      npc = 32'h00400004;
      tick();
      check("in_reset", Address, 32'h00400000);
      Reset = 1'b0;
      tick();
      check("post_reset", Address, 32'h00400004);
      npc = 32'h00400003;
      tick();
      check("low_bits_pass", Address, 32'h00400003);

      // 2: DIV held 34 edges, advances on edge 35
      npc = 32'h00400008;
      tick();
      check("goto_08", Address, 32'h00400008);
      instruction = DIV; npc = 32'h0040000C;
      for (int e = 1; e <= 35; e++) begin
         tick();
         if (e < 35) begin
            check("div_hold_addr", Address, 32'h00400008);
            check("div_hold_busy", {31'b0, md_busy}, 32'd1);
         end else begin
            check("div_adv_addr", Address, 32'h0040000C);
            check("div_adv_busy", {31'b0, md_busy}, 32'd0);
         end
      end
      instruction = NOP;

      // 3a: MULT with MULT_LAT=0 behaves as a normal op
      instruction = MULT; npc = 32'h00400020;
      tick();
      check("mult0_addr", Address, 32'h00400020);
      check("mult0_busy", {31'b0, md_busy}, 32'd0);

      // 4: exception on edge 10 of a DIV hold
      instruction = NOP; npc = 32'h00400008;
      tick();
      instruction = DIV; npc = 32'h0040000C;
      for (int e = 1; e <= 9; e++) tick();
      check("exc_pre_busy", {31'b0, md_busy}, 32'd1);
      exc_req = 1'b1; exc_addr = 32'h180;
      tick();
      check("exc_addr", Address, 32'h00400180);
      check("exc_busy", {31'b0, md_busy}, 32'd0);
`ifdef PC_EPC_EN
      check("exc_epc", epc, 32'h00400008);
`endif
      exc_req = 1'b0; instruction = NOP; npc = 32'h00400184;
      tick();
      check("post_exc_run", Address, 32'h00400184);

      // 5: stall 3 edges inside DIV hold pushes advance to edge 38
      npc = 32'h00400008;
      tick();
      instruction = DIV; npc = 32'h0040000C;
      for (int e = 1; e <= 38; e++) begin
         ext_stall = (e >= 6 && e <= 8);
         tick();
         if (e < 38) begin
            if (e == 7 || e == 20 || e == 35 || e == 37) begin
               check("stall_hold_addr", Address, 32'h00400008);
               check("stall_hold_busy", {31'b0, md_busy}, 32'd1);
            end
         end else begin
            check("stall_adv_addr", Address, 32'h0040000C);
            check("stall_adv_busy", {31'b0, md_busy}, 32'd0);
         end
      end
      ext_stall = 1'b0;

      // stall in RUN freezes a normal advance
      instruction = NOP; npc = 32'h00400050; ext_stall = 1'b1;
      tick();
      check("run_stall", Address, 32'h0040000C);

      // stall together with exception during hold: redirect wins
      ext_stall = 1'b0; npc = 32'h00400008;
      tick();
      instruction = DIV; npc = 32'h0040000C;
      tick(); tick(); tick();
      ext_stall = 1'b1; exc_req = 1'b1; exc_addr = 32'h40;
      tick();
      check("stall_exc_addr", Address, 32'h00400040);
      check("stall_exc_busy", {31'b0, md_busy}, 32'd0);
`ifdef PC_EPC_EN
      check("stall_exc_epc", epc, 32'h00400008);
      exc_req = 1'b0;
      tick();
      check("epc_hold_stall", epc, 32'h00400008);
`endif
      ext_stall = 1'b0; exc_req = 1'b0; instruction = NOP;

      // 3b: MULTU with MULT_LAT=4 advances on edge 5; 6: EXC_BASE wrap
      Reset_b = 1'b0;
      tick();
      check("b_first", Address_b, 32'h00001000);
      instruction_b = MULTU; npc_b = 32'h00001004;
      for (int e = 1; e <= 5; e++) begin
         tick();
         if (e < 5) begin
            check("mult4_hold", Address_b, 32'h00001000);
            check("mult4_busy", {31'b0, md_busy_b}, 32'd1);
         end else begin
            check("mult4_adv", Address_b, 32'h00001004);
            check("mult4_idle", {31'b0, md_busy_b}, 32'd0);
         end
      end
      instruction_b = NOP;
      exc_req_b = 1'b1; exc_addr_b = 32'h200;
      tick();
      check("exc_wrap", Address_b, 32'h00000100);
      exc_req_b = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
